// File: rtl/ps2_key_receiver_if.sv
// Decoded key-event bundle from the PS/2 receiver to the game logic.
`timescale 1ns/1ps
interface ps2_key_receiver_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       scan_ext;
  logic       scan_break;
  logic       parity_err;
  logic       frame_err;
  logic       l_up, l_dn, r_up, r_dn;

  modport master (output scan_code, scan_valid, scan_ext, scan_break,
                         parity_err, frame_err, l_up, l_dn, r_up, r_dn);
  modport slave  (input  scan_code, scan_valid, scan_ext, scan_break,
                         parity_err, frame_err, l_up, l_dn, r_up, r_dn);
endinterface

// File: rtl/ps2_key_receiver.sv
// Receive-only PS/2 keyboard front end: sync/filter pins, deframe bytes,
// strip E0/F0 prefixes, emit one event per key action and paddle held flags.
`timescale 1ns/1ps
module ps2_key_receiver #(
  parameter int         SYNC_STAGES    = 2,
  parameter int         FILTER_LEN     = 8,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] KEY_L_UP       = 8'h1D,
  parameter logic [7:0] KEY_L_DN       = 8'h1B,
  parameter logic [7:0] KEY_R_UP       = 8'h75,
  parameter logic [7:0] KEY_R_DN       = 8'h72
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  ps2_key_receiver_if.master   kb
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sr, dat_sr;
  logic                   clk_s, dat_s, clk_f;
  logic [FW-1:0]          flt_cnt;
  logic                   bit_stb, bit_dat;
  state_t                 state, state_n;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_ok;
  logic [TW-1:0]          tmo_cnt;
  logic                   timeout, frame_ok, perr, ferr;
  logic                   ext_pend, brk_pend;

  assign clk_s = clk_sr[SYNC_STAGES-1];
  assign dat_s = dat_sr[SYNC_STAGES-1];

  // Pins idle high, so sync/filter reset high to avoid a false falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sr  <= '1;
      dat_sr  <= '1;
      clk_f   <= 1'b1;
      flt_cnt <= '0;
      bit_stb <= 1'b0;
      bit_dat <= 1'b1;
    end else begin
      clk_sr  <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      dat_sr  <= {dat_sr[SYNC_STAGES-2:0], ps2_data};
      bit_stb <= 1'b0;
      bit_dat <= dat_s;
      if (clk_s != clk_f) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_f   <= clk_s;
          flt_cnt <= '0;
          bit_stb <= ~clk_s;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign timeout = (state != IDLE) && !bit_stb && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_n  = state;
    frame_ok = 1'b0;
    perr     = 1'b0;
    ferr     = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      ferr    = 1'b1;
    end else if (bit_stb) begin
      case (state)
        IDLE:    if (!bit_dat) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (!bit_dat)     ferr     = 1'b1;
          else if (!par_ok) perr     = 1'b1;
          else              frame_ok = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_ok  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      tmo_cnt <= (state == IDLE || bit_stb) ? '0 : tmo_cnt + TW'(1);
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (bit_stb && state == DATA) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {bit_dat, shreg[7:1]};
      end
      if (bit_stb && state == PARITY) par_ok <= ^{bit_dat, shreg};
    end
  end

  // Decode stage: prefixes only arm pending flags; any other byte is an event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kb.scan_code  <= '0;
      kb.scan_valid <= 1'b0;
      kb.scan_ext   <= 1'b0;
      kb.scan_break <= 1'b0;
      kb.parity_err <= 1'b0;
      kb.frame_err  <= 1'b0;
      kb.l_up       <= 1'b0;
      kb.l_dn       <= 1'b0;
      kb.r_up       <= 1'b0;
      kb.r_dn       <= 1'b0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
    end else begin
      kb.scan_valid <= 1'b0;
      kb.parity_err <= perr;
      kb.frame_err  <= ferr;
      if (perr || ferr) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (frame_ok) begin
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          kb.scan_valid <= 1'b1;
          kb.scan_code  <= shreg;
          kb.scan_ext   <= ext_pend;
          kb.scan_break <= brk_pend;
          ext_pend      <= 1'b0;
          brk_pend      <= 1'b0;
          if (shreg == KEY_L_UP && !ext_pend) kb.l_up <= ~brk_pend;
          if (shreg == KEY_L_DN && !ext_pend) kb.l_dn <= ~brk_pend;
          if (shreg == KEY_R_UP &&  ext_pend) kb.r_up <= ~brk_pend;
          if (shreg == KEY_R_DN &&  ext_pend) kb.r_dn <= ~brk_pend;
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench: 1 MHz system clock, 60 us PS/2 bit period, short timeout.
`timescale 1ns/1ps
module tb_ps2_key_receiver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0, n_perr = 0, n_ferr = 0;
  int   v0, p0, f0;

  ps2_key_receiver_if kb();

  ps2_key_receiver #(.TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kb(kb)
  );

  always #500 clk = ~clk;

  always @(negedge clk) begin
    if (kb.scan_valid) n_valid++;
    if (kb.parity_err) n_perr++;
    if (kb.frame_err)  n_ferr++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
  endtask

  // bits: LSB first {stop, parity, data[7:0], start}
  task automatic send_raw(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      #15us ps2_clk = 1'b0;
      #30us ps2_clk = 1'b1;
      if (glitch && i == 4) begin
        #5us ps2_clk = 1'b0;
        #6us ps2_clk = 1'b1;
        #4us;
      end else begin
        #15us;
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par = 0,
                       input bit stop = 1, input bit glitch = 0);
    logic p;
    p = (~^b) ^ bad_par;
    send_raw({stop, p, b, 1'b0}, 11, glitch);
    #100us;
  endtask

  task automatic chk_keys(input string tag, input logic [3:0] exp);
    chk(tag, int'({kb.l_up, kb.l_dn, kb.r_up, kb.r_dn}), int'(exp));
  endtask

  initial begin
    #3us @(negedge clk);
    chk("rst_code", int'(kb.scan_code), 0);
    chk("rst_flags", int'({kb.scan_valid, kb.scan_ext, kb.scan_break, kb.parity_err, kb.frame_err}), 0);
    chk_keys("rst_keys", 4'b0000);
    reset = 1'b1;
    #20us;

    // 1: W make
    mark(); frame(8'h1D);
    chk("t1_valid", n_valid - v0, 1);
    chk("t1_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), 'h1D << 2);
    chk_keys("t1_keys", 4'b1000);

    // 2: W break
    mark(); frame(8'hF0); frame(8'h1D);
    chk("t2_valid", n_valid - v0, 1);
    chk("t2_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), ('h1D << 2) | 1);
    chk_keys("t2_keys", 4'b0000);

    // 3: up arrow make, break, then non-extended 75
    mark(); frame(8'hE0); frame(8'h75);
    chk("t3_valid", n_valid - v0, 1);
    chk("t3_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), ('h75 << 2) | 2);
    chk_keys("t3_keys", 4'b0010);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("t3b_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), ('h75 << 2) | 3);
    chk_keys("t3b_keys", 4'b0000);
    mark(); frame(8'h75);
    chk("t3c_valid", n_valid - v0, 1);
    chk("t3c_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), 'h75 << 2);
    chk_keys("t3c_keys", 4'b0000);

    // 4: parity error then stop-bit error
    mark(); frame(8'h1B, 1'b1);
    chk("t4_perr", n_perr - p0, 1);
    chk("t4_valid", n_valid - v0, 0);
    chk_keys("t4_keys", 4'b0000);
    mark(); frame(8'h1B, 1'b0, 1'b0);
    chk("t4b_ferr", n_ferr - f0, 1);
    chk("t4b_perr", n_perr - p0, 0);
    chk("t4b_valid", n_valid - v0, 0);

    // 5: truncated frame times out, then down arrow
    mark(); send_raw({2'b11, 8'h55, 1'b0}, 6, 1'b0);
    #400us;
    chk("t5_ferr", n_ferr - f0, 1);
    chk("t5_valid", n_valid - v0, 0);
    mark(); frame(8'hE0); frame(8'h72);
    chk("t5b_valid", n_valid - v0, 1);
    chk("t5b_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), ('h72 << 2) | 2);
    chk_keys("t5b_keys", 4'b0001);

    // 6: short clock glitch is filtered out
    mark(); frame(8'h1B, 1'b0, 1'b1, 1'b1);
    chk("t6_valid", n_valid - v0, 1);
    chk("t6_err", (n_perr - p0) + (n_ferr - f0), 0);
    chk("t6_code", int'(kb.scan_code), 'h1B);
    chk_keys("t6_keys", 4'b0101);

    // 6b: reset mid-frame clears everything; next frame still decodes
    send_raw({2'b11, 8'h00, 1'b0}, 4, 1'b0);
    #10us reset = 1'b0;
    #5us @(negedge clk);
    chk("t6r_code", int'(kb.scan_code), 0);
    chk("t6r_flags", int'({kb.scan_valid, kb.scan_ext, kb.scan_break, kb.parity_err, kb.frame_err}), 0);
    chk_keys("t6r_keys", 4'b0000);
    reset = 1'b1;
    #100us;
    mark(); frame(8'h1D);
    chk("t6r_valid", n_valid - v0, 1);
    chk("t6r_evt", int'({kb.scan_code, kb.scan_ext, kb.scan_break}), 'h1D << 2);
    chk_keys("t6r_keys2", 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
